// File: rtl/io_stream_pkg.sv
// Shared types for the CPU byte-output sequencer.
// FSM state encoding and byte counter width.
package io_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } io_state_t;

  localparam int BYTE_CNT_W = 16;

endpackage

// File: rtl/io_stream_fifo.sv
// Synchronous FIFO for the byte-output path; sync active-low reset.
// Ports: push/wdata in, pop in, rdata (head, 0 when empty), full, empty, count.
module io_stream_fifo
  import io_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;

  // Storage needs no reset; pointers and count define validity.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  assign full  = (count == (ADDR_W+1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_stream_ctrl.sv
// CPU byte-output sequencer: start, buffer, drain, stall, done, overflow.
// Optional byte_count port when IO_STREAM_BYTE_COUNT_EN is defined.
module io_stream_ctrl
  import io_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_W = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_sw,
  input  logic                  cpu_out_flag,
  input  logic [DATA_WIDTH-1:0] cpu_out_data,
  input  logic                  cpu_end_flag,
  output logic                  cpu_start,
  output logic                  cpu_stall,
  output logic                  dev_valid,
  output logic [DATA_WIDTH-1:0] dev_data,
  input  logic                  dev_ready,
  output logic                  busy,
  output logic                  done,
`ifdef IO_STREAM_BYTE_COUNT_EN
  output logic [BYTE_CNT_W-1:0] byte_count,
`endif
  output logic                  overflow
);

  io_state_t       state;
  logic            sw_low_q;
  logic            start_rise;
  logic            fifo_full;
  logic            fifo_empty;
  logic [ADDR_W:0] fifo_count;
  logic            in_run;
  logic            push;
  logic            pop;
  logic            drop;

  // Edge reg holds "switch was low last cycle"; reset value 0
  // keeps a switch already high at reset exit from starting.
  assign start_rise = sw_low_q & start_sw;
  assign in_run     = (state == RUN);
  assign pop        = !fifo_empty & dev_ready;
  assign push       = in_run & cpu_out_flag & (!fifo_full | pop);
  assign drop       = in_run & cpu_out_flag & fifo_full & !pop;

  io_stream_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .wdata (cpu_out_data),
    .pop   (pop),
    .rdata (dev_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      sw_low_q <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sw_low_q <= !start_sw;
      if (drop) overflow <= 1'b1;
      unique case (state)
        IDLE:  if (start_rise) state <= RUN;
        RUN:   if (cpu_end_flag || !start_sw) state <= DRAIN;
        DRAIN: if (fifo_empty) state <= DONE;
        DONE:  if (!start_sw) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IO_STREAM_BYTE_COUNT_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      byte_count <= '0;
    end else if (state == IDLE && start_rise) begin
      byte_count <= '0;
    end else if (pop && byte_count != '1) begin
      byte_count <= byte_count + BYTE_CNT_W'(1);
    end
  end
`endif

  assign cpu_start = in_run;
  assign cpu_stall = in_run &
    (fifo_count == (ADDR_W+1)'(FIFO_DEPTH));
  assign dev_valid = !fifo_empty;
  assign busy      = in_run | (state == DRAIN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_io_stream_ctrl.sv
// Scoreboard bench for io_stream_ctrl with a queue-based reference.
// Directed scenarios followed by a randomized phase.
module tb_io_stream_ctrl;

  localparam int DEPTH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_sw = 1'b0;
  logic       cpu_out_flag = 1'b0;
  logic [7:0] cpu_out_data = 8'h00;
  logic       cpu_end_flag = 1'b0;
  logic       dev_ready = 1'b0;
  logic       cpu_start, cpu_stall, dev_valid;
  logic [7:0] dev_data;
  logic       busy, done, overflow;
`ifdef IO_STREAM_BYTE_COUNT_EN
  logic [15:0] byte_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  io_stream_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .start_sw     (start_sw),
    .cpu_out_flag (cpu_out_flag),
    .cpu_out_data (cpu_out_data),
    .cpu_end_flag (cpu_end_flag),
    .cpu_start    (cpu_start),
    .cpu_stall    (cpu_stall),
    .dev_valid    (dev_valid),
    .dev_data     (dev_data),
    .dev_ready    (dev_ready),
    .busy         (busy),
    .done         (done),
`ifdef IO_STREAM_BYTE_COUNT_EN
    .byte_count   (byte_count),
`endif
    .overflow     (overflow)
  );

  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;

  mst_t       m_st = M_IDLE;
  logic [7:0] m_q[$];
  logic [7:0] sb_q[$];
  bit         m_prev_low = 1'b0;
  bit         m_ovf = 1'b0;
  int         m_cnt = 0;

  // Reference: one clock edge of the specified behaviour.
  task automatic model_step();
    int n;
    bit pp, full, rise;
    if (!reset) begin
      m_st = M_IDLE;
      m_q.delete();
      sb_q.delete();
      m_prev_low = 1'b0;
      m_ovf = 1'b0;
      m_cnt = 0;
      return;
    end
    n = m_q.size();
    pp = (n > 0) && dev_ready;
    full = (n == DEPTH);
    rise = m_prev_low && start_sw;
    if (pp) void'(m_q.pop_front());
    if (m_st == M_RUN && cpu_out_flag) begin
      if (!full || pp) begin
        m_q.push_back(cpu_out_data);
        sb_q.push_back(cpu_out_data);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (m_st == M_IDLE && rise) m_cnt = 0;
    else if (pp && m_cnt < 65535) m_cnt++;
    case (m_st)
      M_IDLE:  if (rise) m_st = M_RUN;
      M_RUN:   if (cpu_end_flag || !start_sw) m_st = M_DRAIN;
      M_DRAIN: if (n == 0) m_st = M_DONE;
      M_DONE:  if (!start_sw) m_st = M_IDLE;
      default: m_st = M_IDLE;
    endcase
    m_prev_low = !start_sw;
  endtask

  task automatic check_outputs();
    logic [5:0] got, exp;
    logic [7:0] ed;
    exp = {m_st == M_RUN,
           (m_st == M_RUN) && (m_q.size() == DEPTH),
           m_q.size() > 0,
           (m_st == M_RUN) || (m_st == M_DRAIN),
           m_st == M_DONE,
           m_ovf};
    got = {cpu_start, cpu_stall, dev_valid, busy, done, overflow};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL flags t=%0t got=%b expected=%b", $time, got, exp);
    end
    ed = (m_q.size() > 0) ? m_q[0] : 8'h00;
    checks++;
    if (dev_data !== ed) begin
      failures++;
      $display("FAIL head t=%0t got=%h expected=%h", $time, dev_data, ed);
    end
`ifdef IO_STREAM_BYTE_COUNT_EN
    checks++;
    if (byte_count !== m_cnt[15:0]) begin
      failures++;
      $display("FAIL byte_count t=%0t got=%0d expected=%0d",
               $time, byte_count, m_cnt);
    end
`endif
  endtask

  task automatic cycle();
    @(negedge clock);
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit r, input bit sw, input bit of,
                       input logic [7:0] d, input bit ef, input bit rdy);
    reset = r;
    start_sw = sw;
    cpu_out_flag = of;
    cpu_out_data = d;
    cpu_end_flag = ef;
    dev_ready = rdy;
    cycle();
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next edge.
  always @(negedge clock) begin : mon
    logic [7:0] e;
    if (reset && dev_valid && dev_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got=%h expected=none", dev_data);
      end else begin
        e = sb_q.pop_front();
        if (dev_data !== e) begin
          failures++;
          $display("FAIL sb_data got=%h expected=%h", dev_data, e);
        end
      end
    end
  end

  initial begin
    bit sw;
    int n;
    // Reset with switch high; stays idle after release.
    drive(0, 1, 0, 8'h00, 0, 0);
    drive(0, 1, 0, 8'h00, 0, 0);
    repeat (3) drive(1, 1, 0, 8'h00, 0, 1);
    // Start edge and short stream.
    drive(1, 0, 0, 8'h00, 0, 1);
    drive(1, 1, 0, 8'h00, 0, 1);
    drive(1, 1, 1, 8'h41, 0, 1);
    drive(1, 1, 1, 8'h42, 0, 1);
    drive(1, 1, 1, 8'h43, 0, 1);
    repeat (2) drive(1, 1, 0, 8'h00, 0, 1);
    // Backpressure to full, then overflow drop, then drain.
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 8'(i), 0, 0);
    drive(1, 1, 1, 8'hFF, 0, 0);
    repeat (10) drive(1, 1, 0, 8'h00, 0, 1);
    // Clear overflow and restart.
    drive(0, 0, 0, 8'h00, 0, 0);
    drive(1, 0, 0, 8'h00, 0, 0);
    drive(1, 1, 0, 8'h00, 0, 0);
    // Full with simultaneous push and pop.
    for (int i = 0; i < 8; i++) drive(1, 1, 1, 8'h10 + 8'(i), 0, 0);
    drive(1, 1, 1, 8'hAA, 0, 1);
    repeat (10) drive(1, 1, 0, 8'h00, 0, 1);
    // End flag with last byte, drain to done.
    drive(1, 1, 1, 8'h5A, 1, 1);
    n = 0;
    while (!done && n < 20) begin
      drive(1, 1, 0, 8'h00, 0, 1);
      n++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout got=%b expected=1", done);
    end
    drive(1, 0, 0, 8'h00, 0, 1);
    drive(1, 1, 0, 8'h00, 0, 1);
    // Mid-run reset with bytes buffered.
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 8'hC0 + 8'(i), 0, 0);
    drive(0, 1, 0, 8'h00, 0, 0);
    drive(1, 1, 0, 8'h00, 0, 1);
    // Randomized traffic.
    sw = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) sw = !sw;
      drive($urandom_range(0, 299) != 0, sw,
            $urandom_range(0, 2) != 0, 8'($urandom),
            $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
